combo_prog_ctrl: RTL and testbench
==================================

Name: combo_prog_ctrl

Overview:
Owns the safe's three-digit combination registers. Drives the selected digit to the dial comparator and runs the user sequence for changing the combination while the safe is unlocked. The sequence is enter three digits, re-enter them to confirm, then commit on a match. It sits beside the master lock FSM: that FSM supplies sel and the unlocked status, and this block supplies ref_digit to the eq comparator.

Parameters:
DW, 5, digit/dial count width in bits
C0_RST, 5'd3, combination digit 0 after reset
C1_RST, 5'd17, combination digit 1 after reset
C2_RST, 5'd9, combination digit 2 after reset
TIMEOUT_CYC, 50_000_000, idle cycles in ENTER/CONFIRM before abort (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
unlocked  in  1  high while master FSM is in its unlocked state
prog_req  in  1  one-cycle pulse, debounced/synchronised, request programming
dirch  in  1  one-cycle pulse on dial direction change; captures current digit
cnt_val  in  DW  current dial counter value
sel  in  2  digit index from master FSM (0,1,2; 3 treated as 0)
ref_digit  out  DW  active combination digit selected by sel, to comparator
prog_busy  out  1  high in ENTER/CONFIRM/CHECK
digit_idx  out  2  index of next digit to capture (0..2), 0 when idle
clr_cnt  out  1  one-cycle pulse requesting dial counter clear
prog_done  out  1  one-cycle pulse: new combination committed
prog_err  out  1  one-cycle pulse: mismatch, timeout or abort

Behaviour:
- Reset values: combo regs = C0_RST/C1_RST/C2_RST, shadow regs = 0, state IDLE, idx 0, timer 0. All pulse outputs, prog_busy and digit_idx are 0.
- All outputs are registered except ref_digit, which is a combinational mux of the active regs by sel. sel=3 selects digit 0.
- States: IDLE, ENTER, CONFIRM, CHECK.
- IDLE: prog_req && unlocked -> ENTER, idx=0, timer cleared, clr_cnt pulses next cycle. prog_req with unlocked low is ignored, with no err.
- ENTER: each dirch writes cnt_val into shadowA[idx] on that edge, increments idx and clears timer. The capture with idx=2 -> CONFIRM, idx=0, clr_cnt pulse.
- CONFIRM: the same capture rules write into shadowB. The capture with idx=2 -> CHECK.
- CHECK (one cycle): shadowA==shadowB for all three digits -> write combo regs = shadowA, prog_done pulse, -> IDLE. Otherwise prog_err pulse, -> IDLE, combo unchanged.
- New ref_digit is visible the cycle after the commit edge. Active combo regs never change outside CHECK.
- Timer counts every cycle in ENTER/CONFIRM without dirch. Reaching TIMEOUT_CYC-1 -> IDLE with prog_err.
- Priority in ENTER/CONFIRM, highest first:
  1. unlocked low -> abort: IDLE, prog_err, no capture.
  2. prog_req -> restart ENTER, idx=0, clr_cnt, shadows kept but overwritten.
  3. dirch -> capture, timer cleared; beats a same-cycle timeout.
  4. timeout.
- dirch or prog_req in CHECK are ignored.
- Async rst mid-sequence restores the reset combination. Power loss/reset therefore reverts to the default combo by design.
- A digit equal to the previous digit or 0 is legal. Full DW range accepted, no wrap logic here.

Decomposition:
- sejf_pkg holds: DW default, state enum IDLE/ENTER/CONFIRM/CHECK (2-bit), default combination localparams.
- One natural sub-module: idle_timer (TIMEOUT_CYC param; inputs clr, en; output expired). Counter width is $clog2(TIMEOUT_CYC).
- Shadow/active regs and the FSM stay in combo_prog_ctrl.

Test Plan:
1. Reset, sel=0/1/2/3 -> ref_digit 3,17,9,3. Outputs all 0.
2. unlocked=1, prog_req, dirch with cnt_val 5,12,30, then again 5,12,30 -> clr_cnt pulses twice, prog_done one cycle, and sel=1 then gives ref_digit=12.
3. Same as 2 but confirm 5,12,31 -> prog_err one cycle, no prog_done, ref_digit still 3/17/9.
4. TIMEOUT_CYC=8: prog_req, one dirch, then 8 idle cycles -> prog_err at timeout, prog_busy falls, combo unchanged. dirch coinciding with expiry cycle -> no err, capture taken.
5. Mid-CONFIRM drop unlocked in same cycle as dirch -> prog_err, no capture, IDLE. Also prog_req while unlocked=0 -> nothing.
6. Commit new combo, then pulse rst mid-ENTER of a second programming -> ref_digit returns to 3/17/9, prog_busy 0.

Source files
------------

// File: rtl/sejf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sejf_pkg                                                   |
// | Brief   : Shared types and default combination for the safe logic.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package sejf_pkg;

  localparam int unsigned c_DW     = 5;
  localparam int unsigned c_COMBO0 = 3;
  localparam int unsigned c_COMBO1 = 17;
  localparam int unsigned c_COMBO2 = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTER   = 2'd1,
    ST_CONFIRM = 2'd2,
    ST_CHECK   = 2'd3
  } state_t;

  // Digit index 3 does not exist; the master FSM may present it and it aliases digit 0.
  function automatic logic [1:0] sel_to_idx(input logic [1:0] sel);
    return (sel == 2'd3) ? 2'd0 : sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/combo_prog_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : combo_prog_ctrl_if                                         |
// | Brief   : Dial/master-FSM side signals of the combination programmer.|
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface combo_prog_ctrl_if
  import sejf_pkg::*;
#(
  parameter int unsigned DW = c_DW
);

  logic          unlocked;
  logic          prog_req;
  logic          dirch;
  logic [DW-1:0] cnt_val;
  logic [1:0]    sel;
  logic [DW-1:0] ref_digit;
  logic          prog_busy;
  logic [1:0]    digit_idx;
  logic          clr_cnt;
  logic          prog_done;
  logic          prog_err;

  modport master (
    output unlocked, prog_req, dirch, cnt_val, sel,
    input  ref_digit, prog_busy, digit_idx, clr_cnt, prog_done, prog_err
  );

  modport slave (
    input  unlocked, prog_req, dirch, cnt_val, sel,
    output ref_digit, prog_busy, digit_idx, clr_cnt, prog_done, prog_err
  );

endinterface
`default_nettype wire

// File: rtl/idle_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : idle_timer                                                 |
// | Brief   : Inactivity counter; flags expiry at TIMEOUT_CYC-1.         |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module idle_timer
  import sejf_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clr,
  input  wire logic en,
  output logic      expired
);

  localparam int unsigned    c_W    = $clog2(TIMEOUT_CYC);
  localparam logic [c_W-1:0] c_LAST = c_W'(TIMEOUT_CYC - 1);

  logic [c_W-1:0] r_cnt;

  // Saturates at the terminal value so a stalled consumer never sees a wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != c_LAST)) begin
      r_cnt <= r_cnt + c_W'(1);
    end
  end

  assign expired = en && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/combo_prog_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : combo_prog_ctrl                                            |
// | Brief   : Holds the safe combination and runs the enter/confirm/     |
// |           commit sequence used to change it while unlocked.          |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module combo_prog_ctrl
  import sejf_pkg::*;
#(
  parameter int unsigned DW          = c_DW,
  parameter int unsigned C0_RST      = c_COMBO0,
  parameter int unsigned C1_RST      = c_COMBO1,
  parameter int unsigned C2_RST      = c_COMBO2,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  wire logic          clk,
  input  wire logic          rst,
  combo_prog_ctrl_if.slave   bus
);

  state_t        r_state;
  logic [1:0]    r_idx;
  logic          r_busy;
  logic          r_clr_cnt;
  logic          r_done;
  logic          r_err;
  logic [DW-1:0] r_combo [3];
  logic [DW-1:0] r_sha   [3];
  logic [DW-1:0] r_shb   [3];

  logic          w_active;
  logic          w_tmr_clr;
  logic          w_expired;
  logic          w_match;
  logic [DW-1:0] w_ref;

  assign w_active  = (r_state == ST_ENTER) || (r_state == ST_CONFIRM);
  // Any event that keeps the sequence alive or restarts it also restarts the idle window.
  assign w_tmr_clr = !w_active || bus.dirch || bus.prog_req || !bus.unlocked;

  idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_tmr_clr),
    .en      (w_active),
    .expired (w_expired)
  );

  assign w_match = (r_sha[0] == r_shb[0]) &&
                   (r_sha[1] == r_shb[1]) &&
                   (r_sha[2] == r_shb[2]);

  always_comb begin
    w_ref = r_combo[0];
    case (sel_to_idx(bus.sel))
      2'd1:    w_ref = r_combo[1];
      2'd2:    w_ref = r_combo[2];
      default: w_ref = r_combo[0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= 2'd0;
      r_busy    <= 1'b0;
      r_clr_cnt <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_combo[0] <= DW'(C0_RST);
      r_combo[1] <= DW'(C1_RST);
      r_combo[2] <= DW'(C2_RST);
      for (int i = 0; i < 3; i++) begin
        r_sha[i] <= '0;
        r_shb[i] <= '0;
      end
    end else begin
      r_clr_cnt <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.prog_req && bus.unlocked) begin
            r_state   <= ST_ENTER;
            r_idx     <= 2'd0;
            r_busy    <= 1'b1;
            r_clr_cnt <= 1'b1;
          end
        end
        ST_ENTER, ST_CONFIRM: begin
          if (!bus.unlocked) begin
            r_state <= ST_IDLE;
            r_idx   <= 2'd0;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else if (bus.prog_req) begin
            r_state   <= ST_ENTER;
            r_idx     <= 2'd0;
            r_clr_cnt <= 1'b1;
          end else if (bus.dirch) begin
            if (r_state == ST_ENTER) begin
              r_sha[r_idx] <= bus.cnt_val;
            end else begin
              r_shb[r_idx] <= bus.cnt_val;
            end
            if (r_idx == 2'd2) begin
              r_idx <= 2'd0;
              if (r_state == ST_ENTER) begin
                r_state   <= ST_CONFIRM;
                r_clr_cnt <= 1'b1;
              end else begin
                r_state <= ST_CHECK;
              end
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end else if (w_expired) begin
            r_state <= ST_IDLE;
            r_idx   <= 2'd0;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (w_match) begin
            for (int i = 0; i < 3; i++) begin
              r_combo[i] <= r_sha[i];
            end
            r_done <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
          r_state <= ST_IDLE;
          r_idx   <= 2'd0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= 2'd0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ref_digit = w_ref;
  assign bus.prog_busy = r_busy;
  assign bus.digit_idx = r_idx;
  assign bus.clr_cnt   = r_clr_cnt;
  assign bus.prog_done = r_done;
  assign bus.prog_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_combo_prog_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_combo_prog_ctrl                                         |
// | Brief   : Directed self-checking bench for combo_prog_ctrl.          |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_combo_prog_ctrl;

  localparam int unsigned c_DW = 5;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  combo_prog_ctrl_if #(.DW(c_DW)) bus ();

  combo_prog_ctrl #(
    .DW          (c_DW),
    .C0_RST      (3),
    .C1_RST      (17),
    .C2_RST      (9),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_dirch(input logic [c_DW-1:0] v);
    bus.cnt_val = v;
    bus.dirch   = 1'b1;
    tick();
    bus.dirch   = 1'b0;
  endtask

  task automatic pulse_req();
    bus.prog_req = 1'b1;
    tick();
    bus.prog_req = 1'b0;
  endtask

  task automatic check_combo(input string tag, input logic [c_DW-1:0] e0,
                             input logic [c_DW-1:0] e1, input logic [c_DW-1:0] e2);
    logic [c_DW-1:0] exp_v [3];
    exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2;
    for (int i = 0; i < 3; i++) begin
      bus.sel = 2'(i);
      #1;
      checks++;
      if (bus.ref_digit !== exp_v[i]) begin
        errors++;
        $display("FAIL %s ref_digit sel=%0d: actual=%0d required=%0d", tag, i, bus.ref_digit, exp_v[i]);
      end
    end
    bus.sel = 2'd0;
  endtask

  task automatic test_reset();
    do_reset();
    check_combo("reset", 5'd3, 5'd17, 5'd9);
    bus.sel = 2'd3;
    #1;
    checks++;
    if (bus.ref_digit !== 5'd3) begin
      errors++;
      $display("FAIL reset sel3: actual=%0d required=3", bus.ref_digit);
    end
    bus.sel = 2'd0;
    checks++;
    if ({bus.prog_busy, bus.digit_idx, bus.clr_cnt, bus.prog_done, bus.prog_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset outputs: actual=%b required=000000",
               {bus.prog_busy, bus.digit_idx, bus.clr_cnt, bus.prog_done, bus.prog_err});
    end
  endtask

  task automatic test_program_ok();
    logic [c_DW-1:0] seq [6] = '{5'd5, 5'd12, 5'd30, 5'd5, 5'd12, 5'd30};
    int nclr  = 0;
    int ndone = 0;
    bus.unlocked = 1'b1;
    pulse_req();
    if (bus.clr_cnt) nclr++;
    checks++;
    if (bus.prog_busy !== 1'b1 || bus.digit_idx !== 2'd0) begin
      errors++;
      $display("FAIL prog_ok enter: actual busy=%b idx=%0d required busy=1 idx=0", bus.prog_busy, bus.digit_idx);
    end
    for (int i = 0; i < 6; i++) begin
      pulse_dirch(seq[i]);
      if (bus.clr_cnt) nclr++;
      if (bus.prog_done) ndone++;
      if (i == 1) begin
        checks++;
        if (bus.digit_idx !== 2'd2) begin
          errors++;
          $display("FAIL prog_ok idx: actual=%0d required=2", bus.digit_idx);
        end
      end
    end
    checks++;
    if (bus.prog_busy !== 1'b1 || bus.prog_done !== 1'b0) begin
      errors++;
      $display("FAIL prog_ok check state: actual busy=%b done=%b required busy=1 done=0", bus.prog_busy, bus.prog_done);
    end
    tick();
    if (bus.prog_done) ndone++;
    checks++;
    if (bus.prog_done !== 1'b1 || bus.prog_busy !== 1'b0 || bus.prog_err !== 1'b0) begin
      errors++;
      $display("FAIL prog_ok commit: actual done=%b busy=%b err=%b required 1/0/0", bus.prog_done, bus.prog_busy, bus.prog_err);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.prog_done) ndone++;
      if (bus.clr_cnt) nclr++;
    end
    checks++;
    if (nclr !== 2) begin
      errors++;
      $display("FAIL prog_ok clr_cnt pulses: actual=%0d required=2", nclr);
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL prog_ok done pulses: actual=%0d required=1", ndone);
    end
    check_combo("prog_ok", 5'd5, 5'd12, 5'd30);
  endtask

  task automatic test_mismatch();
    logic [c_DW-1:0] seq [6] = '{5'd5, 5'd12, 5'd30, 5'd5, 5'd12, 5'd31};
    int nerr  = 0;
    int ndone = 0;
    do_reset();
    bus.unlocked = 1'b1;
    pulse_req();
    for (int i = 0; i < 6; i++) pulse_dirch(seq[i]);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.prog_err) nerr++;
      if (bus.prog_done) ndone++;
    end
    checks++;
    if (nerr !== 1 || ndone !== 0) begin
      errors++;
      $display("FAIL mismatch pulses: actual err=%0d done=%0d required err=1 done=0", nerr, ndone);
    end
    check_combo("mismatch", 5'd3, 5'd17, 5'd9);
  endtask

  task automatic test_timeout();
    bus.unlocked = 1'b1;
    pulse_req();
    pulse_dirch(5'd7);
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (bus.prog_busy !== 1'b1 || bus.prog_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout early: actual busy=%b err=%b required busy=1 err=0", bus.prog_busy, bus.prog_err);
    end
    tick();
    checks++;
    if (bus.prog_err !== 1'b1 || bus.prog_busy !== 1'b0 || bus.digit_idx !== 2'd0) begin
      errors++;
      $display("FAIL timeout expiry: actual err=%b busy=%b idx=%0d required 1/0/0", bus.prog_err, bus.prog_busy, bus.digit_idx);
    end
    tick();
    checks++;
    if (bus.prog_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout err width: actual=%b required=0", bus.prog_err);
    end
    check_combo("timeout", 5'd3, 5'd17, 5'd9);
    // dirch arriving on the expiry cycle keeps the sequence alive
    pulse_req();
    pulse_dirch(5'd7);
    for (int i = 0; i < 7; i++) tick();
    pulse_dirch(5'd8);
    checks++;
    if (bus.prog_err !== 1'b0 || bus.prog_busy !== 1'b1 || bus.digit_idx !== 2'd2) begin
      errors++;
      $display("FAIL timeout race: actual err=%b busy=%b idx=%0d required 0/1/2", bus.prog_err, bus.prog_busy, bus.digit_idx);
    end
    pulse_dirch(5'd9);
    pulse_dirch(5'd7);
    pulse_dirch(5'd8);
    pulse_dirch(5'd9);
    tick();
    checks++;
    if (bus.prog_done !== 1'b1) begin
      errors++;
      $display("FAIL timeout race commit: actual done=%b required=1", bus.prog_done);
    end
    tick();
    check_combo("timeout_race", 5'd7, 5'd8, 5'd9);
  endtask

  task automatic test_abort();
    bus.unlocked = 1'b1;
    pulse_req();
    pulse_dirch(5'd1);
    pulse_dirch(5'd2);
    pulse_dirch(5'd3);
    pulse_dirch(5'd1);
    bus.unlocked = 1'b0;
    pulse_dirch(5'd2);
    checks++;
    if (bus.prog_err !== 1'b1 || bus.prog_busy !== 1'b0 || bus.digit_idx !== 2'd0) begin
      errors++;
      $display("FAIL abort: actual err=%b busy=%b idx=%0d required 1/0/0", bus.prog_err, bus.prog_busy, bus.digit_idx);
    end
    tick();
    pulse_req();
    checks++;
    if ({bus.prog_busy, bus.clr_cnt, bus.prog_err, bus.prog_done} !== 4'b0) begin
      errors++;
      $display("FAIL locked req: actual=%b required=0000", {bus.prog_busy, bus.clr_cnt, bus.prog_err, bus.prog_done});
    end
    tick();
    checks++;
    if (bus.prog_busy !== 1'b0) begin
      errors++;
      $display("FAIL locked req busy: actual=%b required=0", bus.prog_busy);
    end
    check_combo("abort", 5'd7, 5'd8, 5'd9);
  endtask

  task automatic test_reset_mid();
    bus.unlocked = 1'b1;
    pulse_req();
    pulse_dirch(5'd10);
    pulse_dirch(5'd20);
    pulse_dirch(5'd30);
    pulse_dirch(5'd10);
    pulse_dirch(5'd20);
    pulse_dirch(5'd30);
    tick();
    tick();
    check_combo("reset_mid pre", 5'd10, 5'd20, 5'd30);
    pulse_req();
    pulse_dirch(5'd4);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.prog_busy !== 1'b0 || bus.digit_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid async: actual busy=%b idx=%0d required 0/0", bus.prog_busy, bus.digit_idx);
    end
    check_combo("reset_mid", 5'd3, 5'd17, 5'd9);
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.prog_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid release: actual busy=%b required=0", bus.prog_busy);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b0;
    bus.unlocked = 1'b0;
    bus.prog_req = 1'b0;
    bus.dirch    = 1'b0;
    bus.cnt_val  = '0;
    bus.sel      = 2'd0;
    test_reset();
    test_program_ok();
    test_mismatch();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
